// File: rtl/payload_frame_arbiter.sv
// Multi-channel framed payload sender: round-robin arbitration over NUM_CH
// request channels, each frame serialised to a shared UART TX as
// event code, length, payload bytes and an optional XOR checksum.
module payload_frame_arbiter #(
    parameter int unsigned         NUM_CH      = 4,
    parameter int unsigned         MAX_BYTES   = 24,
    // Channel k code lives in bits [8k+7:8k]: ch0 = AD, ch1 = AE, ch2 = AF, ch3 = B0.
    parameter logic [NUM_CH*8-1:0] EVENT_CODES = (NUM_CH*8)'(32'hB0AF_AEAD),
    parameter bit                  CHECKSUM_EN = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             habilitar_envio,
    input  logic [NUM_CH*MAX_BYTES*8-1:0] buffer_envio,
    input  logic [NUM_CH*8-1:0]           comprimento,
    input  logic                          uart_ocupado,
    output logic                          iniciar_envio,
    output logic [7:0]                    dado_saida,
    output logic [NUM_CH-1:0]             envio_concluido,
    output logic                          ocupado,
    output logic [2:0]                    canal_ativo
);

    localparam int unsigned SLICE_W  = MAX_BYTES * 8;
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SUM_W    = CH_W + 1;
    localparam logic [SUM_W-1:0] NUM_CH_S = SUM_W'(NUM_CH);
    localparam logic [7:0]  MAX_LEN  = 8'(MAX_BYTES);
    // Index of the final byte relative to L: checksum sits at L+2, last payload at L+1.
    localparam logic [8:0]  TAIL     = CHECKSUM_EN ? 9'd2 : 9'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_DONE
    } state_t;

    // Per-channel views of the flat input buses.
    logic [SLICE_W-1:0] slice_w [NUM_CH];
    logic [7:0]         code_w  [NUM_CH];
    logic [7:0]         len_w   [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign slice_w[g] = buffer_envio[g*SLICE_W +: SLICE_W];
        assign code_w[g]  = EVENT_CODES[g*8 +: 8];
        assign len_w[g]   = comprimento[g*8 +: 8];
    end

    state_t              state_q,   state_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]     ptr_q,     ptr_d;
    logic [CH_W-1:0]     gnt_q,     gnt_d;
    logic [SLICE_W-1:0]  payload_q, payload_d;
    logic [7:0]          code_q,    code_d;
    logic [7:0]          len_q,     len_d;
    logic [7:0]          idx_q,     idx_d;
    logic [7:0]          chk_q,     chk_d;
    logic                last_q,    last_d;
    logic                strobe_q,  strobe_d;
    logic [7:0]          dado_q,    dado_d;
    logic [NUM_CH-1:0]   done_q,    done_d;
    logic                busy_q,    busy_d;
    logic [2:0]          canal_q,   canal_d;

    logic                found;
    logic [CH_W-1:0]     win;
    logic [CH_W-1:0]     ptr_nxt;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    nsum;
    logic [7:0]          grant_len;

    logic [7:0]          cur_byte;
    logic                is_payload;
    logic                is_last;
    logic                send_now;

    // Round-robin search: first pending channel at or above the pointer, wrapping.
    always_comb begin : arb_search
        found     = 1'b0;
        win       = '0;
        sum       = '0;
        nsum      = '0;
        ptr_nxt   = '0;
        grant_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr_q} + SUM_W'(i);
            if (sum >= NUM_CH_S) begin
                sum = sum - NUM_CH_S;
            end
            if (!found && pending_q[CH_W'(sum)]) begin
                found = 1'b1;
                win   = CH_W'(sum);
            end
        end
        nsum = {1'b0, win} + SUM_W'(1);
        if (nsum >= NUM_CH_S) begin
            nsum = '0;
        end
        ptr_nxt   = CH_W'(nsum);
        grant_len = (len_w[win] > MAX_LEN) ? MAX_LEN : len_w[win];
    end

    // Byte selected by the frame index; payload is consumed from the top of a shift register.
    always_comb begin : byte_select
        cur_byte   = chk_q;
        is_payload = 1'b0;
        if (idx_q == 8'd0) begin
            cur_byte = code_q;
        end else if (idx_q == 8'd1) begin
            cur_byte = len_q;
        end else if ({1'b0, idx_q} <= ({1'b0, len_q} + 9'd1)) begin
            cur_byte   = payload_q[SLICE_W-1 -: 8];
            is_payload = 1'b1;
        end
        is_last = ({1'b0, idx_q} == ({1'b0, len_q} + TAIL));
    end

    // Next-state and registered-output logic. The strobe is registered, so the UART
    // idle check is made the cycle before the strobe; SEND holds while the UART is busy.
    always_comb begin : fsm_next
        state_d   = state_q;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        payload_d = payload_q;
        code_d    = code_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        last_d    = last_q;
        strobe_d  = 1'b0;
        dado_d    = dado_q;
        done_d    = '0;
        canal_d   = canal_q;
        send_now  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    pending_d[win] = 1'b0;
                    ptr_d          = ptr_nxt;
                    gnt_d          = win;
                    payload_d      = slice_w[win];
                    code_d         = code_w[win];
                    len_d          = grant_len;
                    idx_d          = 8'd0;
                    chk_d          = 8'd0;
                    last_d         = 1'b0;
                    canal_d        = 3'(win);
                    if (!uart_ocupado) begin
                        strobe_d = 1'b1;
                        dado_d   = code_w[win];
                        chk_d    = code_w[win];
                        idx_d    = 8'd1;
                        state_d  = ST_WAIT_BUSY;
                    end else begin
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (!uart_ocupado) begin
                    send_now = 1'b1;
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_ocupado) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!uart_ocupado) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                        done_d  = NUM_CH'(1) << gnt_q;
                    end else begin
                        send_now = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                canal_d = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (send_now) begin
            strobe_d = 1'b1;
            dado_d   = cur_byte;
            chk_d    = chk_q ^ cur_byte;
            state_d  = ST_WAIT_BUSY;
            if (is_payload) begin
                payload_d = payload_q << 8;
            end
            if (is_last) begin
                last_d = 1'b1;
            end else begin
                idx_d  = idx_q + 8'd1;
            end
        end

        // A pulse landing on the grant cycle re-arms the channel.
        pending_d = pending_d | habilitar_envio;
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame and drops all requests.
    always_ff @(posedge clock) begin : regs
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            payload_q <= '0;
            code_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            last_q    <= 1'b0;
            strobe_q  <= 1'b0;
            dado_q    <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            canal_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            payload_q <= payload_d;
            code_q    <= code_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            last_q    <= last_d;
            strobe_q  <= strobe_d;
            dado_q    <= dado_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            canal_q   <= canal_d;
        end
    end

    assign iniciar_envio   = strobe_q;
    assign dado_saida      = dado_q;
    assign envio_concluido = done_q;
    assign ocupado         = busy_q;
    assign canal_ativo     = canal_q;

endmodule

// File: tb/tb_payload_frame_arbiter.sv
// Scoreboard bench for payload_frame_arbiter: a checksum instance and a
// no-checksum instance, each with a UART model that goes busy the cycle after
// a strobe and stays busy for 3 cycles.
module tb_payload_frame_arbiter;

    localparam int NCH = 4;
    localparam int MB  = 24;
    localparam int SW  = MB * 8;

    typedef struct packed {
        logic       is_done;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NCH-1:0]       hab0, hab1;
    logic [NCH*SW-1:0]    buf0, buf1;
    logic [NCH*8-1:0]     len0, len1;
    logic                 hold0;
    logic                 busy0, busy1;
    logic [1:0]           u0, u1;
    logic                 ini0, ini1;
    logic [7:0]           dado0, dado1;
    logic [NCH-1:0]       done0, done1;
    logic                 ocu0, ocu1;
    logic [2:0]           can0, can1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   fall0    = -10;
    int   fall1    = -10;
    logic pb0      = 1'b0;
    logic pb1      = 1'b0;

    payload_frame_arbiter dut0 (
        .clock(clk), .reset(rst), .habilitar_envio(hab0), .buffer_envio(buf0),
        .comprimento(len0), .uart_ocupado(busy0), .iniciar_envio(ini0),
        .dado_saida(dado0), .envio_concluido(done0), .ocupado(ocu0), .canal_ativo(can0)
    );

    payload_frame_arbiter #(.CHECKSUM_EN(1'b0)) dut1 (
        .clock(clk), .reset(rst), .habilitar_envio(hab1), .buffer_envio(buf1),
        .comprimento(len1), .uart_ocupado(busy1), .iniciar_envio(ini1),
        .dado_saida(dado1), .envio_concluido(done1), .ocupado(ocu1), .canal_ativo(can1)
    );

    // UART models.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)            u0 <= 2'd0;
        else if (ini0)      u0 <= 2'd3;
        else if (u0 != 2'd0) u0 <= u0 - 2'd1;
        if (rst)            u1 <= 2'd0;
        else if (ini1)      u1 <= 2'd3;
        else if (u1 != 2'd0) u1 <= u1 - 2'd1;
    end
    assign busy0 = hold0 | (u0 != 2'd0);
    assign busy1 = (u1 != 2'd0);

    // Monitor for the checksum instance.
    always @(negedge clk) begin
        if (pb0 && !busy0) fall0 = cyc;
        pb0 = busy0;
        if (ini0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected_strobe: got byte %02h, required no strobe", dado0);
            end else begin
                e0 = q0.pop_front();
                if (e0.is_done || e0.val !== dado0) begin
                    failures++;
                    $display("FAIL dut0_byte: got strobe %02h, required done=%0b val=%02h", dado0, e0.is_done, e0.val);
                end
            end
        end
        if (done0 != '0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected_done: got %b, required no pulse", done0);
            end else begin
                e0 = q0.pop_front();
                if (!e0.is_done || e0.val[3:0] !== done0) begin
                    failures++;
                    $display("FAIL dut0_done: got %b, required done=%0b val=%02h", done0, e0.is_done, e0.val);
                end
            end
            checks++;
            if (cyc != fall0 + 1) begin
                failures++;
                $display("FAIL dut0_done_timing: got cycle %0d, required %0d", cyc, fall0 + 1);
            end
        end
    end

    // Monitor for the no-checksum instance.
    always @(negedge clk) begin
        if (pb1 && !busy1) fall1 = cyc;
        pb1 = busy1;
        if (ini1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_strobe: got byte %02h, required no strobe", dado1);
            end else begin
                e1 = q1.pop_front();
                if (e1.is_done || e1.val !== dado1) begin
                    failures++;
                    $display("FAIL dut1_byte: got strobe %02h, required done=%0b val=%02h", dado1, e1.is_done, e1.val);
                end
            end
        end
        if (done1 != '0) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_done: got %b, required no pulse", done1);
            end else begin
                e1 = q1.pop_front();
                if (!e1.is_done || e1.val[3:0] !== done1) begin
                    failures++;
                    $display("FAIL dut1_done: got %b, required done=%0b val=%02h", done1, e1.is_done, e1.val);
                end
            end
            checks++;
            if (cyc != fall1 + 1) begin
                failures++;
                $display("FAIL dut1_done_timing: got cycle %0d, required %0d", cyc, fall1 + 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic pb(input int which, input logic [7:0] v);
        exp_t e;
        e.is_done = 1'b0;
        e.val     = v;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic pd(input int which, input logic [3:0] mask);
        exp_t e;
        e.is_done = 1'b1;
        e.val     = {4'h0, mask};
        if (which == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic set_byte(input int which, input int ch, input int i, input logic [7:0] v);
        if (which == 0) buf0[ch*SW + (MB-1-i)*8 +: 8] = v;
        else            buf1[ch*SW + (MB-1-i)*8 +: 8] = v;
    endtask

    task automatic pulse0(input logic [3:0] m);
        @(negedge clk) hab0 = m;
        @(negedge clk) hab0 = '0;
    endtask

    // Wait until the scoreboard is empty and the instance idle, bounded.
    task automatic drain(input int which, input string name);
        int n;
        n = 0;
        while (n < 800 && (which == 0 ? (q0.size() != 0 || ocu0) : (q1.size() != 0 || ocu1))) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 800) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending entries, required 0", name,
                     (which == 0) ? q0.size() : q1.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; hab0 = '0; hab1 = '0; buf0 = '0; buf1 = '0; len0 = '0; len1 = '0; hold0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_dut0", {19'd0, ini0, dado0, done0, ocu0, can0}, 32'd0);
        check("reset_outputs_dut1", {19'd0, ini1, dado1, done1, ocu1, can1}, 32'd0);
        rst = 1'b0;

        // 1: single frame ch0, L=2; checksum AD^02^12^34 = 89.
        set_byte(0, 0, 0, 8'h12); set_byte(0, 0, 1, 8'h34); len0[7:0] = 8'd2;
        pb(0, 8'hAD); pb(0, 8'h02); pb(0, 8'h12); pb(0, 8'h34); pb(0, 8'h89); pd(0, 4'b0001);
        @(negedge clk) hab0 = 4'b0001;
        @(negedge clk) hab0 = '0;
        check("latency_t1_no_strobe", {31'd0, ini0}, 32'd0);
        check("latency_t1_idle", {31'd0, ocu0}, 32'd0);
        @(negedge clk);
        check("latency_t2_strobe", {31'd0, ini0}, 32'd1);
        check("latency_t2_busy", {31'd0, ocu0}, 32'd1);
        drain(0, "single_frame");

        // 2: round robin, ch1 and ch3 together with L=0, then ch0+ch1.
        buf0 = '0; len0 = '0;
        pb(0, 8'hAE); pb(0, 8'h00); pb(0, 8'hAE); pd(0, 4'b0010);
        pb(0, 8'hB0); pb(0, 8'h00); pb(0, 8'hB0); pd(0, 4'b1000);
        pulse0(4'b1010);
        @(negedge clk);
        check("rr_first_channel", {29'd0, can0}, 32'd1);
        drain(0, "rr_pair");
        pb(0, 8'hAD); pb(0, 8'h00); pb(0, 8'hAD); pd(0, 4'b0001);
        pb(0, 8'hAE); pb(0, 8'h00); pb(0, 8'hAE); pd(0, 4'b0010);
        pulse0(4'b0011);
        @(negedge clk);
        check("rr_wrap_channel", {29'd0, can0}, 32'd0);
        check("rr_wrap_busy", {31'd0, ocu0}, 32'd1);
        drain(0, "rr_wrap");

        // 3: clamp ch2 length 30 -> 24 bytes 40..57; XOR of payload is 0, checksum AF^18 = B7.
        for (int i = 0; i < MB; i++) set_byte(0, 2, i, 8'(8'h40 + i));
        len0[23:16] = 8'd30;
        pb(0, 8'hAF); pb(0, 8'h18);
        for (int i = 0; i < MB; i++) pb(0, 8'(8'h40 + i));
        pb(0, 8'hB7); pd(0, 4'b0100);
        pulse0(4'b0100);
        drain(0, "clamp");

        // 4: no-checksum instance, ch2 L=1 payload FF -> exactly AF,01,FF.
        set_byte(1, 2, 0, 8'hFF); len1[23:16] = 8'd1;
        pb(1, 8'hAF); pb(1, 8'h01); pb(1, 8'hFF); pd(1, 4'b0100);
        @(negedge clk) hab1 = 4'b0100;
        @(negedge clk) hab1 = '0;
        drain(1, "no_checksum");

        // 5: reset while waiting for busy after the third byte, ch1 pending as well.
        buf0 = '0; len0 = '0;
        set_byte(0, 0, 0, 8'h12); set_byte(0, 0, 1, 8'h34); len0[7:0] = 8'd2; len0[15:8] = 8'd1;
        pb(0, 8'hAD); pb(0, 8'h02); pb(0, 8'h12);
        pulse0(4'b0011);
        n = 0;
        while (n < 200 && !(ini0 && dado0 == 8'h12)) begin
            @(negedge clk);
            n++;
        end
        check("reset_target_reached", {31'd0, (n < 200)}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_outputs", {19'd0, ini0, dado0, done0, ocu0, can0}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("reset_drops_pending", {31'd0, ocu0}, 32'd0);
        check("reset_queue_consumed", q0.size(), 32'd0);

        // 6: UART busy before SEND, payload changed after grant; checksum AE^02^5A^C3 = 35.
        buf0 = '0; len0 = '0;
        set_byte(0, 1, 0, 8'h5A); set_byte(0, 1, 1, 8'hC3); len0[15:8] = 8'd2;
        pb(0, 8'hAE); pb(0, 8'h02); pb(0, 8'h5A); pb(0, 8'hC3); pb(0, 8'h35); pd(0, 4'b0010);
        hold0 = 1'b1;
        pulse0(4'b0010);
        @(negedge clk);
        set_byte(0, 1, 0, 8'h00); set_byte(0, 1, 1, 8'hFF); len0[15:8] = 8'd5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("held_busy_no_strobe", {31'd0, ini0}, 32'd0);
        end
        check("held_busy_channel", {29'd0, can0}, 32'd1);
        hold0 = 1'b0;
        drain(0, "stability");

        check("final_queue_dut0", q0.size(), 32'd0);
        check("final_queue_dut1", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
